// File: rtl/pe_result_drain_pkg.sv
// Shared types and sizing helpers for the PE result drain path.
package systola_pkg;
  localparam int DW_RES = 32;

  typedef logic [DW_RES-1:0] res_t;

  typedef enum logic {IDLE, STREAM} drain_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int iw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pe_result_drain_if.sv
// Valid/ready result stream from the drain toward writeback.
interface pe_result_drain_if #(
  parameter int DW = 32,
  parameter int IW = 6
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;

  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/pe_result_drain_idx_gen.sv
// Drain word counter with stream-order mapping and last-word flag.
// Build option DRAIN_COLMAJOR_EN selects column-major order (default row-major).
module drain_idx_gen
  import systola_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int N    = ROWS * COLS,
  parameter int IW   = iw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  output logic [IW-1:0] nxt_idx,
  output logic          nxt_last
);
  logic [IW-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (load)     cnt_nxt = '0;
    else if (adv) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;

  // Outputs describe the word that will be presented after this edge.
  always_comb begin
`ifdef DRAIN_COLMAJOR_EN
    nxt_idx = IW'((int'(cnt_nxt) % ROWS) * COLS + int'(cnt_nxt) / ROWS);
`else
    nxt_idx = cnt_nxt;
`endif
    nxt_last = (int'(cnt_nxt) == N - 1);
  end
endmodule

// File: rtl/pe_result_drain.sv
// Snapshots all PE results once every PE is valid and streams them one word per cycle.
// Build option DRAIN_COLMAJOR_EN switches the stream to column-major order.
module pe_result_drain
  import systola_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = DW_RES,
  localparam int N   = ROWS * COLS,
  localparam int IW  = iw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_res   [0:N-1],
  input  logic          in_valid [0:N-1],
  input  logic          cap_en,
  input  logic          clr_ovr,
  output logic          cap_ack,
  output logic          busy,
  output logic          overrun,
  pe_result_drain_if.master strm
);
  drain_state_t  state, state_nxt;
  logic          cap_cond, capture, done, hs;
  logic [IW-1:0] nxt_idx;
  logic          nxt_last;
  logic [DW-1:0] snap [0:N-1];

  always_comb begin
    cap_cond = cap_en;
    for (int k = 0; k < N; k++) cap_cond = cap_cond & in_valid[k];
  end

  assign hs = strm.out_valid & strm.out_ready;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (cap_cond) begin capture = 1'b1; state_nxt = STREAM; end
      STREAM: if (hs && strm.out_last) begin done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  assign busy           = (state == STREAM);
  assign strm.out_valid = (state == STREAM);

  drain_idx_gen #(.ROWS(ROWS), .COLS(COLS), .N(N), .IW(IW)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .adv      (hs),
    .nxt_idx  (nxt_idx),
    .nxt_last (nxt_last)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < N; k++) snap[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < N; k++) snap[k] <= in_res[k];
    end

  // First word bypasses the buffer since it is being written on the same edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cap_ack       <= 1'b0;
      strm.out_data <= '0;
      strm.out_idx  <= '0;
      strm.out_last <= 1'b0;
    end else begin
      cap_ack <= capture;
      if (capture) begin
        strm.out_data <= in_res[nxt_idx];
        strm.out_idx  <= nxt_idx;
        strm.out_last <= nxt_last;
      end else if (done) begin
        strm.out_last <= 1'b0;
      end else if (hs) begin
        strm.out_data <= snap[nxt_idx];
        strm.out_idx  <= nxt_idx;
        strm.out_last <= nxt_last;
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst)                              overrun <= 1'b0;
    else if (state == STREAM && cap_cond) overrun <= 1'b1;
    else if (clr_ovr)                     overrun <= 1'b0;
endmodule

// File: tb/tb_pe_result_drain.sv
// Randomized self-checking bench for pe_result_drain against an order/snapshot model.
module tb_pe_result_drain;
  import systola_pkg::*;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;
  localparam int IW   = iw_of(N);

  logic clk = 1'b0;
  logic rst;
  res_t in_res   [0:N-1];
  logic in_valid [0:N-1];
  logic cap_en, clr_ovr, cap_ack, busy, overrun;

  pe_result_drain_if #(.DW(DW_RES), .IW(IW)) sif ();

  pe_result_drain #(.ROWS(ROWS), .COLS(COLS), .DW(DW_RES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_res   (in_res),
    .in_valid (in_valid),
    .cap_en   (cap_en),
    .clr_ovr  (clr_ovr),
    .cap_ack  (cap_ack),
    .busy     (busy),
    .overrun  (overrun),
    .strm     (sif.master)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  res_t snap [0:N-1];
  int   ord  [0:N-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; capture lands on the following posedge.
  task automatic capture();
    for (int k = 0; k < N; k++) snap[k] = in_res[k];
    cap_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("cap_ack", cap_ack, 1);
    cap_en = 1'b0;
  endtask

  // mode 0: ready high, 1: pattern 1,0,0,1, 2: random. ovr_at injects a capture attempt.
  task automatic drain(input int mode, input int ovr_at, input int stop_at);
    int pos = 0;
    int cyc = 0;
    bit rdy;
    bit ovr_done = 0;
    while (pos < stop_at && cyc < 2000) begin
      chk("out_valid", sif.out_valid, 1);
      chk("busy", busy, 1);
      chk("out_data", sif.out_data, snap[ord[pos]]);
      chk("out_idx", sif.out_idx, ord[pos]);
      chk("out_last", sif.out_last, (pos == N - 1));
      if (cyc > 0) chk("cap_ack_stream", cap_ack, 0);
      clr_ovr = 1'b0;
      cap_en  = 1'b0;
      if (pos == ovr_at && !ovr_done) begin
        for (int k = 0; k < N; k++) in_res[k] = 500 + k;
        cap_en   = 1'b1;
        clr_ovr  = 1'b1;
        ovr_done = 1;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sif.out_ready = rdy;
      @(posedge clk);
      if (rdy) pos++;
      cyc++;
      @(negedge clk);
    end
    cap_en  = 1'b0;
    clr_ovr = 1'b0;
    if (cyc >= 2000) chk("drain_timeout", 0, 1);
    if (stop_at == N) begin
      if (mode == 0) chk("drain_cycles", cyc, N);
      chk("idle_valid", sif.out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_last", sif.out_last, 0);
    end
  endtask

  initial begin
    int i = 0;
`ifdef DRAIN_COLMAJOR_EN
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin ord[i] = r * COLS + c; i++; end
`else
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin ord[i] = r * COLS + c; i++; end
`endif

    rst = 1'b1; cap_en = 1'b0; clr_ovr = 1'b0; sif.out_ready = 1'b0;
    for (int k = 0; k < N; k++) begin in_res[k] = 100 + k; in_valid[k] = 1'b1; end
    repeat (2) @(negedge clk);
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", cap_ack, 0);
    chk("rst_last", sif.out_last, 0);
    chk("rst_data", sif.out_data, 0);
    chk("rst_idx", sif.out_idx, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic drain and backpressure.
    capture(); drain(0, -1, N);
    capture(); drain(1, -1, N);

    // Overrun mid-stream, coincident with a clear; snapshot must be untouched.
    for (int k = 0; k < N; k++) in_res[k] = 100 + k;
    capture(); drain(2, 10, N);
    chk("ovr_set", overrun, 1);
    clr_ovr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr_ovr = 1'b0;
    chk("ovr_clr", overrun, 0);
    capture(); drain(0, -1, N);
    chk("ovr_clean", overrun, 0);

    // Partial valid blocks capture until the missing PE reports.
    for (int k = 0; k < N; k++) in_res[k] = $urandom;
    in_valid[37] = 1'b0;
    cap_en = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("part_ack", cap_ack, 0);
      chk("part_valid", sif.out_valid, 0);
    end
    in_valid[37] = 1'b1;
    capture(); drain(2, -1, N);

    // Async reset mid-drain, then a clean restart.
    for (int k = 0; k < N; k++) in_res[k] = $urandom;
    capture(); drain(0, -1, 20);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", sif.out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_last", sif.out_last, 0);
    chk("arst_data", sif.out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) in_res[k] = k;
    capture(); drain(2, -1, N);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
